// File: rtl/ibex_multdiv_ctrl_pkg.sv
// Shared M-extension definitions: operator encodings and the issue/response
// controller state encoding used by ibex_multdiv_ctrl.
package ibex_multdiv_ctrl_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MDC_IDLE  = 2'b00,
    MDC_RUN   = 2'b01,
    MDC_DRAIN = 2'b10,
    MDC_RESP  = 2'b11
  } md_ctrl_state_e;

endpackage

// File: rtl/ibex_multdiv_ctrl_if.sv
// Bundle of the controller's request, response and multdiv-unit signals, used
// by the EX block to wire the controller to the decoder and the unit.
interface ibex_multdiv_ctrl_if;
  import ibex_multdiv_ctrl_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [1:0]          req_signed;
  logic [MD_WIDTH-1:0] req_a;
  logic [MD_WIDTH-1:0] req_b;
  logic                kill;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [MD_WIDTH-1:0] rsp_result;

  logic                md_mult_en;
  logic                md_div_en;
  logic [1:0]          md_operator;
  logic [1:0]          md_signed_mode;
  logic [MD_WIDTH-1:0] md_op_a;
  logic [MD_WIDTH-1:0] md_op_b;
  logic [MD_WIDTH-1:0] md_result;
  logic                md_valid;
  logic                busy;

  // EX-stage side: issues requests, consumes responses, may flush.
  modport master (
    output req_valid, req_op, req_signed, req_a, req_b, kill, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, busy
  );

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_signed, req_a, req_b, kill, rsp_ready,
           md_result, md_valid,
    output req_ready, rsp_valid, rsp_result, busy,
           md_mult_en, md_div_en, md_operator, md_signed_mode, md_op_a, md_op_b
  );

  // Multiply/divide unit side.
  modport unit (
    input  md_mult_en, md_div_en, md_operator, md_signed_mode, md_op_a, md_op_b,
    output md_result, md_valid
  );

endinterface

// File: rtl/ibex_multdiv_ctrl.sv
// Issue/response controller for the multdiv unit: latches one operation, keeps
// the unit enabled until completion, drains killed operations silently.
module ibex_multdiv_ctrl
  import ibex_multdiv_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [1:0]          req_op_i,
  input  logic [1:0]          req_signed_i,
  input  logic [MD_WIDTH-1:0] req_a_i,
  input  logic [MD_WIDTH-1:0] req_b_i,
  input  logic                kill_i,

  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [MD_WIDTH-1:0] rsp_result_o,

  output logic                md_mult_en_o,
  output logic                md_div_en_o,
  output logic [1:0]          md_operator_o,
  output logic [1:0]          md_signed_mode_o,
  output logic [MD_WIDTH-1:0] md_op_a_o,
  output logic [MD_WIDTH-1:0] md_op_b_o,
  input  logic [MD_WIDTH-1:0] md_result_i,
  input  logic                md_valid_i,
  output logic                busy_o
);

  md_ctrl_state_e      state_q, state_d;
  md_op_e              op_q, op_d;
  logic [1:0]          signed_q, signed_d;
  logic [MD_WIDTH-1:0] a_q, a_d;
  logic [MD_WIDTH-1:0] b_q, b_d;
  logic [MD_WIDTH-1:0] result_q, result_d;
  logic                unit_en;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    signed_d = signed_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;

    unique case (state_q)
      MDC_IDLE: begin
        if (req_valid_i && !kill_i) begin
          op_d     = md_op_e'(req_op_i);
          signed_d = req_signed_i;
          a_d      = req_a_i;
          b_d      = req_b_i;
          state_d  = MDC_RUN;
        end
      end
      MDC_RUN: begin
        // A kill coinciding with completion needs no drain: the unit is done.
        if (md_valid_i) begin
          if (kill_i) begin
            state_d = MDC_IDLE;
          end else begin
            result_d = md_result_i;
            state_d  = MDC_RESP;
          end
        end else if (kill_i) begin
          state_d = MDC_DRAIN;
        end
      end
      MDC_DRAIN: begin
        // The unit freezes rather than resets when disabled, so it must finish.
        if (md_valid_i) begin
          state_d = MDC_IDLE;
        end
      end
      MDC_RESP: begin
        if (kill_i || rsp_ready_i) begin
          state_d = MDC_IDLE;
        end
      end
      default: state_d = MDC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MDC_IDLE;
      op_q     <= MD_OP_MULL;
      signed_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      signed_q <= signed_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign unit_en = (state_q == MDC_RUN) || (state_q == MDC_DRAIN);

  // Operator bit 1 separates the divide family (DIV/REM) from multiplies.
  assign md_div_en_o      = unit_en &  op_q[1];
  assign md_mult_en_o     = unit_en & ~op_q[1];
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = signed_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;
  assign busy_o           = unit_en;

  assign req_ready_o  = (state_q == MDC_IDLE);
  assign rsp_valid_o  = (state_q == MDC_RESP);
  assign rsp_result_o = result_q;

endmodule

// File: tb/tb_ibex_multdiv_ctrl.sv
// Bench for ibex_multdiv_ctrl with a behavioural multdiv unit stub; expected
// results come from a vector table and pass through a scoreboard queue.
module tb_ibex_multdiv_ctrl;
  import ibex_multdiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_multdiv_ctrl_if mif();

  ibex_multdiv_ctrl dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (mif.req_valid),
    .req_ready_o      (mif.req_ready),
    .req_op_i         (mif.req_op),
    .req_signed_i     (mif.req_signed),
    .req_a_i          (mif.req_a),
    .req_b_i          (mif.req_b),
    .kill_i           (mif.kill),
    .rsp_valid_o      (mif.rsp_valid),
    .rsp_ready_i      (mif.rsp_ready),
    .rsp_result_o     (mif.rsp_result),
    .md_mult_en_o     (mif.md_mult_en),
    .md_div_en_o      (mif.md_div_en),
    .md_operator_o    (mif.md_operator),
    .md_signed_mode_o (mif.md_signed_mode),
    .md_op_a_o        (mif.md_op_a),
    .md_op_b_o        (mif.md_op_b),
    .md_result_i      (mif.md_result),
    .md_valid_i       (mif.md_valid),
    .busy_o           (mif.busy)
  );

  // ---------------- behavioural multdiv unit ----------------
  function automatic int unit_lat(input logic [1:0] op, input logic [31:0] b);
    if (op == MD_OP_MULL) return 3;
    if (op == MD_OP_MULH) return 4;
    return (b == 32'd0) ? 2 : 37;
  endfunction

  function automatic logic [31:0] unit_calc(input logic [1:0] op, input logic [1:0] sgn,
                                            input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] sa, sb;
    logic signed [65:0] p;
    logic signed [31:0] qa, qb;
    sa = {sgn[0] & a[31], a};
    sb = {sgn[1] & b[31], b};
    p  = sa * sb;
    qa = a;
    qb = b;
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      default: begin
        if (b == 32'd0) return (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
        if (sgn == 2'b11) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (op == MD_OP_DIV) ? a : 32'd0;
          return (op == MD_OP_DIV) ? 32'(qa / qb) : 32'(qa % qb);
        end
        return (op == MD_OP_DIV) ? a / b : a % b;
      end
    endcase
  endfunction

  int unit_cnt;
  logic unit_en;
  assign unit_en       = mif.md_mult_en | mif.md_div_en;
  assign mif.md_valid  = unit_en && (unit_cnt == unit_lat(mif.md_operator, mif.md_op_b) - 1);
  assign mif.md_result = unit_calc(mif.md_operator, mif.md_signed_mode, mif.md_op_a, mif.md_op_b);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       unit_cnt <= 0;
    else if (unit_en) unit_cnt <= mif.md_valid ? 0 : unit_cnt + 1;
  end

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_a = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t v, input string tag);
    @(negedge clk);
    mif.req_valid  = 1'b1;
    mif.req_op     = v.op;
    mif.req_signed = v.sgn;
    mif.req_a      = v.a;
    mif.req_b      = v.b;
    chk({tag, " req_ready before accept"}, 32'(mif.req_ready), 32'd1);
    @(posedge clk);
    #1 mif.req_valid = 1'b0;
    last_a = v.a;
  endtask

  // Issue, wait for the response, optionally hold it back, then retire it
  // with rsp_ready or drop it with kill.
  task automatic run_op(input vec_t v, input string tag, input int hold, input bit kill_rsp);
    int lat;
    int busy_n;
    bit got;
    logic [31:0] er;
    int el;
    exp_q.push_back(v.res);
    lat_q.push_back(v.lat);
    issue(v, tag);
    lat = 0; busy_n = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (mif.busy) busy_n++;
      if (lat == 1) begin
        chk({tag, " md_operator"}, 32'(mif.md_operator), 32'(v.op));
        chk({tag, " md_signed_mode"}, 32'(mif.md_signed_mode), 32'(v.sgn));
        chk({tag, " md_op_a"}, mif.md_op_a, v.a);
        chk({tag, " md_op_b"}, mif.md_op_b, v.b);
        chk({tag, " md_div_en"}, 32'(mif.md_div_en), 32'(v.op[1]));
        chk({tag, " md_mult_en"}, 32'(mif.md_mult_en), 32'(!v.op[1]));
      end
      if (mif.rsp_valid) got = 1'b1;
    end
    er = exp_q.pop_front();
    el = lat_q.pop_front();
    if (!got) begin
      chk({tag, " response timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, " result"}, mif.rsp_result, er);
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " busy cycles"}, 32'(busy_n), 32'(el - 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " held rsp_valid"}, 32'(mif.rsp_valid), 32'd1);
      chk({tag, " held rsp_result"}, mif.rsp_result, er);
      chk({tag, " held req_ready"}, 32'(mif.req_ready), 32'd0);
      chk({tag, " held enables"}, 32'(unit_en), 32'd0);
    end
    if (kill_rsp) mif.kill = 1'b1;
    else          mif.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    mif.kill = 1'b0;
    mif.rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, " req_ready after retire"}, 32'(mif.req_ready), 32'd1);
    chk({tag, " rsp_valid after retire"}, 32'(mif.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int n;
    bit seen;

    vecs[0] = '{MD_OP_MULL, 2'b00, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 4};
    vecs[1] = '{MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5};
    vecs[2] = '{MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[3] = '{MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 38};
    vecs[4] = '{MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 38};
    vecs[5] = '{MD_OP_DIV,  2'b00, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 3};
    vecs[6] = '{MD_OP_REM,  2'b00, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 3};
    vecs[7] = '{MD_OP_MULL, 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 4};
    vecs[8] = '{MD_OP_MULL, 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 4};
    vecs[9] = '{MD_OP_DIV,  2'b00, 32'd100,       32'd7,         32'd14,        38};

    mif.req_valid = 1'b0; mif.req_op = '0; mif.req_signed = '0;
    mif.req_a = '0; mif.req_b = '0; mif.kill = 1'b0; mif.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(mif.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(mif.rsp_valid), 32'd0);
    chk("reset enables", {30'd0, mif.md_mult_en, mif.md_div_en}, 32'd0);
    chk("reset busy", 32'(mif.busy), 32'd0);
    chk("reset md_operator", 32'(mif.md_operator), 32'd0);
    chk("reset md_signed_mode", 32'(mif.md_signed_mode), 32'd0);
    chk("reset md_op_a", mif.md_op_a, 32'd0);
    chk("reset md_op_b", mif.md_op_b, 32'd0);
    chk("reset rsp_result", mif.rsp_result, 32'd0);
    rst_n = 1'b1;

    // Table-driven main function
    for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i), 0, 1'b0);

    // Back-pressure, then a kill dropping a held response
    run_op(vecs[0], "bp_mull", 5, 1'b0);
    run_op(vecs[3], "bp_div_kill", 5, 1'b1);

    // Kill in the accept cycle cancels the accept
    @(negedge clk);
    mif.req_valid = 1'b1; mif.kill = 1'b1;
    mif.req_op = MD_OP_MULL; mif.req_a = 32'hDEAD_BEEF; mif.req_b = 32'd1;
    @(posedge clk);
    #1 mif.req_valid = 1'b0; mif.kill = 1'b0;
    @(negedge clk);
    chk("kill_accept req_ready", 32'(mif.req_ready), 32'd1);
    chk("kill_accept busy", 32'(mif.busy), 32'd0);
    chk("kill_accept md_op_a", mif.md_op_a, last_a);

    // Kill together with completion discards the result
    issue(vecs[7], "kill_done");
    n = 0;
    while (!mif.md_valid && n < 60) begin @(negedge clk); n++; end
    chk("kill_done md_valid seen", 32'(mif.md_valid), 32'd1);
    mif.kill = 1'b1;
    @(posedge clk);
    #1 mif.kill = 1'b0;
    @(negedge clk);
    chk("kill_done rsp_valid", 32'(mif.rsp_valid), 32'd0);
    chk("kill_done req_ready", 32'(mif.req_ready), 32'd1);
    chk("kill_done busy", 32'(mif.busy), 32'd0);

    // Kill at cycle 10 of a DIV: drain with enable held, no response
    v = vecs[9];
    issue(v, "drain");
    for (int i = 0; i < 10; i++) @(negedge clk);
    mif.kill = 1'b1;
    @(posedge clk);
    #1 mif.kill = 1'b0;
    n = 10; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 15) mif.kill = 1'b1;
      if (n == 16) mif.kill = 1'b0;
      if (n == 11 || n == 20 || mif.md_valid) begin
        chk($sformatf("drain div_en c%0d", n), 32'(mif.md_div_en), 32'd1);
        chk($sformatf("drain rsp_valid c%0d", n), 32'(mif.rsp_valid), 32'd0);
        chk($sformatf("drain md_op_b c%0d", n), mif.md_op_b, v.b);
      end
      if (mif.md_valid) seen = 1'b1;
    end
    mif.kill = 1'b0;
    chk("drain completion cycle", 32'(n), 32'd37);
    @(negedge clk);
    chk("drain req_ready after", 32'(mif.req_ready), 32'd1);
    chk("drain rsp_valid after", 32'(mif.rsp_valid), 32'd0);
    chk("drain div_en after", 32'(mif.md_div_en), 32'd0);
    run_op(vecs[7], "post_drain_mull", 0, 1'b0);

    // Asynchronous reset mid-operation
    issue(vecs[3], "midreset");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset req_ready", 32'(mif.req_ready), 32'd1);
    chk("midreset busy", 32'(mif.busy), 32'd0);
    chk("midreset div_en", 32'(mif.md_div_en), 32'd0);
    chk("midreset md_op_a", mif.md_op_a, 32'd0);
    chk("midreset rsp_result", mif.rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[8], "post_reset_mull", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_multdiv_ctrl.md
# ibex_multdiv_ctrl

Issue/response controller sitting between the EX-stage decoder and the fast multiply/divide unit. It accepts one M-extension operation per valid/ready handshake and latches its operands. It then holds the unit's enables asserted until the unit reports completion, and returns the 32-bit result on a valid/ready response channel. Because the unit's internal state machines freeze rather than reset when their enable drops, the controller also owns cancellation: killed operations are drained to completion and their result is discarded.

## Interface
- No parameters; operand width fixed at 32.
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  operation request
- req_ready_o  out  1  controller can accept a request
- req_op_i  in  2  MD_OP_MULL/MULH/DIV/REM
- req_signed_i  in  2  signed mode, bit0 = operand A, bit1 = operand B
- req_a_i, req_b_i  in  32 each  operands
- kill_i  in  1  cancel the in-flight operation (pipeline flush)
- rsp_valid_o  out  1  result available
- rsp_ready_i  in  1  consumer takes result
- rsp_result_o  out  32  result
- md_mult_en_o, md_div_en_o  out  1 each  unit enables, mutually exclusive
- md_operator_o  out  2  latched op
- md_signed_mode_o  out  2  latched signed mode
- md_op_a_o, md_op_b_o  out  32 each  latched operands
- md_result_i  in  32  unit result
- md_valid_i  in  1  unit completion strobe
- busy_o  out  1  unit owns the shared ALU adder; the ALU must not use it

## Operation
- States: IDLE, RUN, DRAIN, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch op, signed mode and both operands, then go to RUN.
  - kill_i in the same cycle as accept cancels the accept: no latch, stay IDLE.
- RUN:
  - md_div_en_o = op[1]; md_mult_en_o = ~op[1].
  - On md_valid_i without kill_i: register md_result_i into the result register, go to RESP.
- RUN with kill_i, md_valid_i low: go to DRAIN.
- RUN with kill_i and md_valid_i together: discard the result, go to IDLE.
- DRAIN:
  - Enable stays asserted exactly as in RUN; latched operands are held.
  - On md_valid_i, go to IDLE; no response is produced.
  - kill_i is ignored.
- RESP:
  - rsp_valid_o = 1, enables deasserted.
  - On rsp_ready_i, go to IDLE.
  - kill_i drops the response and goes to IDLE, whatever rsp_ready_i is.
- busy_o = 1 in RUN and DRAIN.
- Latched operands and md_* outputs stay stable from accept until the controller returns to IDLE.
- rsp_result_o stays stable while rsp_valid_o is high.
- Illegal state encoding recovers to IDLE.

## Timing
- Reset values:
  - state = IDLE, so req_ready_o = 1.
  - rsp_valid_o, both enables and busy_o = 0.
  - All latched data, md_operator_o, md_signed_mode_o and rsp_result_o = 0.
- Enable is first asserted in the cycle after accept.
- rsp_valid_o rises the cycle after md_valid_i.
- Unit latency counted in enabled cycles:
  - MULL: 3.
  - MULH: 4.
  - DIV/REM: 37.
  - Divide by zero: 2.
- Request-to-response latency = unit latency + 1.
- Throughput: one operation per (latency + 2) cycles; a new request is accepted only in IDLE.
- Reset mid-operation returns to IDLE immediately. The unit is reset by the same rst_ni, so no drain is needed.

## Structure
- Reuse the existing MD_OP_* constants from the shared core package.
- Add the controller state enum (IDLE/RUN/DRAIN/RESP) to the same package.
- Single flat module with no sub-modules; the multdiv unit is instantiated alongside it in the EX block, not inside.

## Test plan
- MULL with A = 0x0000_1234, B = 0x0000_0010 → response 0x0001_2340, 4 cycles after accept; busy_o high for exactly 3 cycles.
- MULH signed 2'b11 with A = 0xFFFF_FFFF, B = 0xFFFF_FFFF → 0x0000_0000; MULH unsigned with the same operands → 0xFFFF_FFFE.
- DIV signed with A = -7, B = 2 → 0xFFFF_FFFD (-3); REM with the same operands → 0xFFFF_FFFF (-1); each 38 cycles after accept.
- DIV with A = 7, B = 0 → 0xFFFF_FFFF after 3 cycles; REM with A = 7, B = 0 → 0x0000_0007.
- Kill at cycle 10 of a DIV:
  - DRAIN keeps md_div_en_o high until md_valid_i; no rsp_valid_o.
  - A following MULL 3×5 returns 15.
- Back-pressure: rsp_ready_i held low for 5 cycles → rsp_valid_o and rsp_result_o stable, req_ready_o low. A kill during RESP drops the response and req_ready_o is high the next cycle.
